// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants, enums and helper functions for the BNN stream loader.
// Optional build macro BNN_LOADER_CHKSUM_EN adds the CHK state used for trailing
// XOR checksum bytes.
package bnn_pkg;

    localparam int IMG_BITS    = 784;
    localparam int IMG_BYTES   = 98;
    localparam int K_BITS      = 25;
    localparam int FC_BITS     = 20;
    localparam int CONV1_DEPTH = 90;
    localparam int CONV2_DEPTH = 1080;
    localparam int FC_DEPTH    = 480;

    typedef enum logic [1:0] {
        IMG   = 2'd0,
        CONV1 = 2'd1,
        CONV2 = 2'd2,
        FC    = 2'd3
    } layer_e;

    typedef enum logic [2:0] {
        HDR       = 3'd0,
        ADDR      = 3'd1,
        OFFS      = 3'd2,
        PAY       = 3'd3,
`ifdef BNN_LOADER_CHKSUM_EN
        CHK       = 3'd4,
`endif
        EMIT_IMG  = 3'd5,
        EMIT_KER  = 3'd6,
        DROP_WAIT = 3'd7
    } state_e;

    // Number of payload bytes following the header/addr/offset bytes
    function automatic logic [6:0] payload_bytes(input layer_e layer);
        case (layer)
            IMG:     return 7'(IMG_BYTES);
            FC:      return 7'd3;
            default: return 7'd4;
        endcase
    endfunction

    // True when addr is a legal write address for the given weight layer
    function automatic logic addr_in_range(input layer_e layer, input logic [10:0] addr);
        case (layer)
            CONV1:   return addr < 11'(CONV1_DEPTH);
            CONV2:   return addr < 11'(CONV2_DEPTH);
            FC:      return addr < 11'(FC_DEPTH);
            default: return 1'b1;
        endcase
    endfunction

    // fc writes only carry FC_BITS weights; the trailing kernel bits read as zero
    function automatic logic [K_BITS-1:0] mask_bits(input layer_e layer,
                                                    input logic [K_BITS-1:0] bits);
        if (layer == FC)
            return bits & {{(K_BITS-FC_BITS){1'b0}}, {FC_BITS{1'b1}}};
        return bits;
    endfunction

endpackage

// File: rtl/bnn_bit_packer.sv
// bnn_bit_packer: writes one byte, MSB first, into a wide vector starting at
// bit_idx (byte bit 7 lands at bit_idx, bit 0 at bit_idx+7). Bits past the end
// of the vector are discarded.
module bnn_bit_packer #(
    parameter int W     = 784,
    parameter int IDX_W = 10
) (
    input  logic [W-1:0]     vec_in,
    input  logic [7:0]       byte_in,
    input  logic [IDX_W-1:0] bit_idx,
    output logic [W-1:0]     vec_out
);

    // Insert the eight byte bits at their target positions
    always_comb begin
        vec_out = vec_in;
        for (int k = 0; k < 8; k++) begin
            if (int'(bit_idx) + k < W)
                vec_out[int'(bit_idx) + k] = byte_in[7-k];
        end
    end

endmodule

// File: rtl/bnn_stream_loader.sv
// bnn_stream_loader: parses a byte-wide host stream into 784-bit binary images
// (valid/ready) and one-cycle conv1/conv2/fc weight-write strobes.
// Optional build macro BNN_LOADER_CHKSUM_EN: every packet carries a trailing
// XOR checksum byte; mismatching packets are dropped and the held image is
// restored from a shadow copy.
module bnn_stream_loader
    import bnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0]          s_data,
    output logic                image_out_valid,
    input  logic                image_out_ready,
    output logic [IMG_BITS-1:0] image_out,
    output logic                kernel_out_valid,
    output logic [1:0]          kernel_out_layer,
    output logic [10:0]         kernel_out_addr,
    output logic [7:0]          kernel_out_offset,
    output logic [K_BITS-1:0]   kernel_out_bits,
    output logic                err_sticky
);

    state_e              state;
    layer_e              layer_q;
    logic [2:0]          addr_hi;
    logic [10:0]         addr_q;
    logic [7:0]          offs_q;
    logic                addr_ok;
    logic [6:0]          byte_cnt;
    logic [K_BITS-1:0]   kbits;
    logic [K_BITS-1:0]   kbits_pack;
    logic [K_BITS-1:0]   kbits_emit;
    logic [IMG_BITS-1:0] img_pack;
    logic                accept;
    logic                last_pay;
    logic                pkt_done;
    logic                unused_hdr;
`ifdef BNN_LOADER_CHKSUM_EN
    logic [7:0]          chk_acc;
    logic [IMG_BITS-1:0] shadow;
    logic                chk_bad;
`endif

    assign accept     = s_valid & s_ready;
    assign last_pay   = (byte_cnt == payload_bytes(layer_q) - 7'd1);
    // Header bits [5:3] carry no meaning
    assign unused_hdr = ^s_data[5:3];

`ifdef BNN_LOADER_CHKSUM_EN
    assign pkt_done   = (state == CHK) && accept && (s_data == chk_acc);
    assign chk_bad    = (state == CHK) && accept && (s_data != chk_acc);
    assign kbits_emit = mask_bits(layer_q, kbits);
`else
    assign pkt_done   = (state == PAY) && accept && last_pay;
    assign kbits_emit = mask_bits(layer_q, kbits_pack);
`endif

    bnn_bit_packer #(.W(IMG_BITS), .IDX_W(10)) u_img_packer (
        .vec_in  (image_out),
        .byte_in (s_data),
        .bit_idx ({byte_cnt, 3'b000}),
        .vec_out (img_pack)
    );

    bnn_bit_packer #(.W(K_BITS), .IDX_W(5)) u_ker_packer (
        .vec_in  (kbits),
        .byte_in (s_data),
        .bit_idx ({byte_cnt[1:0], 3'b000}),
        .vec_out (kbits_pack)
    );

    // Packet parser FSM with registered handshake and output fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= HDR;
            s_ready           <= 1'b0;
            image_out_valid   <= 1'b0;
            image_out         <= '0;
            kernel_out_valid  <= 1'b0;
            kernel_out_layer  <= '0;
            kernel_out_addr   <= '0;
            kernel_out_offset <= '0;
            kernel_out_bits   <= '0;
            err_sticky        <= 1'b0;
            layer_q           <= IMG;
            addr_hi           <= '0;
            addr_q            <= '0;
            offs_q            <= '0;
            addr_ok           <= 1'b0;
            byte_cnt          <= '0;
            kbits             <= '0;
`ifdef BNN_LOADER_CHKSUM_EN
            chk_acc           <= '0;
            shadow            <= '0;
`endif
        end else begin
            kernel_out_valid <= 1'b0;
            case (state)
                HDR: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        layer_q  <= layer_e'(s_data[7:6]);
                        addr_hi  <= s_data[2:0];
                        byte_cnt <= '0;
`ifdef BNN_LOADER_CHKSUM_EN
                        chk_acc  <= s_data;
`endif
                        if (s_data[7:6] == 2'd0) begin
                            state  <= PAY;
`ifdef BNN_LOADER_CHKSUM_EN
                            shadow <= image_out;
`endif
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (accept) begin
                        addr_q  <= {addr_hi, s_data};
                        addr_ok <= addr_in_range(layer_q, {addr_hi, s_data});
                        state   <= OFFS;
`ifdef BNN_LOADER_CHKSUM_EN
                        chk_acc <= chk_acc ^ s_data;
`endif
                    end
                end
                OFFS: begin
                    if (accept) begin
                        offs_q   <= s_data;
                        byte_cnt <= '0;
                        state    <= PAY;
`ifdef BNN_LOADER_CHKSUM_EN
                        chk_acc  <= chk_acc ^ s_data;
`endif
                    end
                end
                PAY: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 7'd1;
                        if (layer_q == IMG)
                            image_out <= img_pack;
                        else
                            kbits <= kbits_pack;
`ifdef BNN_LOADER_CHKSUM_EN
                        chk_acc <= chk_acc ^ s_data;
                        if (last_pay)
                            state <= CHK;
`endif
                    end
                end
`ifdef BNN_LOADER_CHKSUM_EN
                CHK: begin
                    if (chk_bad) begin
                        err_sticky <= 1'b1;
                        state      <= HDR;
                        if (layer_q == IMG)
                            image_out <= shadow;
                    end
                end
`endif
                EMIT_IMG: begin
                    if (image_out_ready) begin
                        image_out_valid <= 1'b0;
                        state           <= HDR;
                        s_ready         <= 1'b1;
                    end
                end
                EMIT_KER, DROP_WAIT: begin
                    state   <= HDR;
                    s_ready <= 1'b1;
                end
                default: state <= HDR;
            endcase

            // End of a complete, accepted packet: hand off or drop
            if (pkt_done) begin
                s_ready <= 1'b0;
                if (layer_q == IMG) begin
                    state           <= EMIT_IMG;
                    image_out_valid <= 1'b1;
                end else if (addr_ok) begin
                    state             <= EMIT_KER;
                    kernel_out_valid  <= 1'b1;
                    kernel_out_layer  <= layer_q;
                    kernel_out_addr   <= addr_q;
                    kernel_out_offset <= offs_q;
                    kernel_out_bits   <= kbits_emit;
                end else begin
                    state      <= DROP_WAIT;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bnn_stream_loader.sv
// tb_bnn_stream_loader: directed bench for bnn_stream_loader (image assembly,
// backpressure, kernel strobes, address range errors, mid-packet reset and the
// optional BNN_LOADER_CHKSUM_EN checksum path).
`timescale 1ns/1ps
module tb_bnn_stream_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         image_out_valid;
    logic         image_out_ready;
    logic [783:0] image_out;
    logic         kernel_out_valid;
    logic [1:0]   kernel_out_layer;
    logic [10:0]  kernel_out_addr;
    logic [7:0]   kernel_out_offset;
    logic [24:0]  kernel_out_bits;
    logic         err_sticky;

    int           checks = 0;
    int           failures = 0;
    int           strobe_cnt = 0;
    int           s0;
    logic         stable;
    logic [7:0]   pkt [0:127];
    int           pkt_len;
    logic [783:0] exp_img;
`ifdef BNN_LOADER_CHKSUM_EN
    logic         corrupt_chk = 1'b0;
`endif

    bnn_stream_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .image_out_valid   (image_out_valid),
        .image_out_ready   (image_out_ready),
        .image_out         (image_out),
        .kernel_out_valid  (kernel_out_valid),
        .kernel_out_layer  (kernel_out_layer),
        .kernel_out_addr   (kernel_out_addr),
        .kernel_out_offset (kernel_out_offset),
        .kernel_out_bits   (kernel_out_bits),
        .err_sticky        (err_sticky)
    );

    always #5 clk = ~clk;

    // Count weight strobes (value seen during the cycle ending at this edge)
    always @(posedge clk) begin
        if (kernel_out_valid === 1'b1)
            strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [783:0] got, input logic [783:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one byte from a negedge and return at the negedge after it is taken
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (s_ready !== 1'b1) begin
            check_eq("s_ready_timeout", 784'(s_ready), 784'(1));
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_pkt();
`ifdef BNN_LOADER_CHKSUM_EN
        logic [7:0] x;
`endif
        for (int i = 0; i < pkt_len; i++)
            send_byte(pkt[i]);
`ifdef BNN_LOADER_CHKSUM_EN
        x = 8'h00;
        for (int i = 0; i < pkt_len; i++)
            x ^= pkt[i];
        send_byte(corrupt_chk ? ~x : x);
`endif
    endtask

    function automatic logic pix(input int mode, input int r, input int c);
        case (mode)
            0:       return ((r + c) % 2) == 1;
            1:       return (r == c) || (c == 0) || (r == 27);
            default: return (r < 14) && (c > 3);
        endcase
    endfunction

    // Build an image packet and the expected image for a pixel pattern
    task automatic build_img(input int mode);
        logic p;
        pkt[0] = 8'h00;
        for (int n = 0; n < 784; n++) begin
            p = pix(mode, n / 28, n % 28);
            pkt[1 + n / 8][7 - (n % 8)] = p;
            exp_img[n] = p;
        end
        pkt_len = 99;
    endtask

    task automatic build_ker(input logic [7:0] h, input logic [7:0] a, input logic [7:0] o,
                             input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3, input int len);
        pkt[0] = h; pkt[1] = a; pkt[2] = o;
        pkt[3] = p0; pkt[4] = p1; pkt[5] = p2; pkt[6] = p3;
        pkt_len = len;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        image_out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_s_ready",    784'(s_ready), 784'(0));
        check_eq("rst_img_valid",  784'(image_out_valid), 784'(0));
        check_eq("rst_image",      image_out, 784'(0));
        check_eq("rst_k_valid",    784'(kernel_out_valid), 784'(0));
        check_eq("rst_k_fields",   784'({kernel_out_layer, kernel_out_addr, kernel_out_offset, kernel_out_bits}), 784'(0));
        check_eq("rst_err",        784'(err_sticky), 784'(0));

        rst_n = 1'b1;
        @(negedge clk);
        check_eq("s_ready_after_rst", 784'(s_ready), 784'(1));

        // Image (r+c)%2 with consumer ready
        image_out_ready = 1'b1;
        build_img(0);
        send_pkt();
        check_eq("img1_valid",   784'(image_out_valid), 784'(1));
        check_eq("img1_s_ready", 784'(s_ready), 784'(0));
        check_eq("img1_px1",     784'(image_out[1]), 784'(1));
        check_eq("img1_px0",     784'(image_out[0]), 784'(0));
        check_eq("img1_data",    image_out, exp_img);
        @(negedge clk);
        check_eq("img1_valid_drop", 784'(image_out_valid), 784'(0));
        check_eq("img1_s_ready_back", 784'(s_ready), 784'(1));

        // Image with backpressure
        image_out_ready = 1'b0;
        build_img(1);
        send_pkt();
        check_eq("img2_valid", 784'(image_out_valid), 784'(1));
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (image_out_valid !== 1'b1 || image_out !== exp_img || s_ready !== 1'b0)
                stable = 1'b0;
        end
        check_eq("bp_stable", 784'(stable), 784'(1));
        check_eq("img2_data", image_out, exp_img);
        image_out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_valid_drop", 784'(image_out_valid), 784'(0));
        check_eq("bp_s_ready",    784'(s_ready), 784'(1));
        image_out_ready = 1'b0;

        // conv2 write at the top legal address
        build_ker(8'h84, 8'h37, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'h80, 7);
        s0 = strobe_cnt;
        send_pkt();
        check_eq("c2_valid",  784'(kernel_out_valid), 784'(1));
        check_eq("c2_layer",  784'(kernel_out_layer), 784'(2));
        check_eq("c2_addr",   784'(kernel_out_addr), 784'(11'h437));
        check_eq("c2_offset", 784'(kernel_out_offset), 784'(8'h5A));
        check_eq("c2_bits",   784'(kernel_out_bits), 784'(25'h1FFFFFF));
        check_eq("c2_s_ready_low", 784'(s_ready), 784'(0));
        @(negedge clk);
        check_eq("c2_one_cycle", 784'(kernel_out_valid), 784'(0));
        check_eq("c2_strobes", 784'(strobe_cnt - s0), 784'(1));
        check_eq("c2_s_ready_back", 784'(s_ready), 784'(1));

        // conv1 at the top legal address, bit 24 set
        build_ker(8'h40, 8'h59, 8'h22, 8'h12, 8'h34, 8'h56, 8'hF8, 7);
        send_pkt();
        check_eq("c1_valid", 784'(kernel_out_valid), 784'(1));
        check_eq("c1_layer", 784'(kernel_out_layer), 784'(1));
        check_eq("c1_addr",  784'(kernel_out_addr), 784'(11'd89));
        check_eq("c1_bits",  784'(kernel_out_bits), 784'(25'h16A2C48));
        check_eq("c1_err",   784'(err_sticky), 784'(0));
        @(negedge clk);

        // conv1 out of range: consumed, no strobe, sticky error
        build_ker(8'h40, 8'h5A, 8'h22, 8'h00, 8'h11, 8'h22, 8'h33, 7);
        s0 = strobe_cnt;
        send_pkt();
        check_eq("oob_err", 784'(err_sticky), 784'(1));
        check_eq("oob_no_valid", 784'(kernel_out_valid), 784'(0));
        repeat (2) @(negedge clk);
        check_eq("oob_no_strobe", 784'(strobe_cnt - s0), 784'(0));

        // fc packet afterwards
        build_ker(8'hC0, 8'h09, 8'h11, 8'hF0, 8'h0F, 8'hA0, 8'h00, 6);
        send_pkt();
        check_eq("fc_valid",  784'(kernel_out_valid), 784'(1));
        check_eq("fc_layer",  784'(kernel_out_layer), 784'(3));
        check_eq("fc_addr",   784'(kernel_out_addr), 784'(11'd9));
        check_eq("fc_offset", 784'(kernel_out_offset), 784'(8'h11));
        check_eq("fc_bits",   784'(kernel_out_bits), 784'(25'h005F00F));
        check_eq("fc_err_kept", 784'(err_sticky), 784'(1));
        check_eq("img_hold",  image_out, exp_img);
        @(negedge clk);

        // Reset after 40 image payload bytes
        build_img(2);
        for (int i = 0; i < 41; i++)
            send_byte(pkt[i]);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_s_ready", 784'(s_ready), 784'(0));
        check_eq("mrst_image",   image_out, 784'(0));
        check_eq("mrst_valids",  784'({image_out_valid, kernel_out_valid}), 784'(0));
        check_eq("mrst_k_fields", 784'({kernel_out_layer, kernel_out_addr, kernel_out_offset, kernel_out_bits}), 784'(0));
        check_eq("mrst_err",     784'(err_sticky), 784'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        image_out_ready = 1'b1;
        send_pkt();
        check_eq("img3_valid", 784'(image_out_valid), 784'(1));
        check_eq("img3_data",  image_out, exp_img);
        @(negedge clk);
        check_eq("img3_done", 784'(image_out_valid), 784'(0));
        image_out_ready = 1'b0;

`ifdef BNN_LOADER_CHKSUM_EN
        // Bad checksum on conv1: dropped with error
        build_ker(8'h40, 8'h05, 8'h22, 8'h12, 8'h34, 8'h56, 8'h78, 7);
        corrupt_chk = 1'b1;
        s0 = strobe_cnt;
        send_pkt();
        check_eq("chk_bad_no_valid", 784'(kernel_out_valid), 784'(0));
        check_eq("chk_bad_err", 784'(err_sticky), 784'(1));
        repeat (2) @(negedge clk);
        check_eq("chk_bad_no_strobe", 784'(strobe_cnt - s0), 784'(0));
        // Good checksum: strobe
        corrupt_chk = 1'b0;
        send_pkt();
        check_eq("chk_ok_valid", 784'(kernel_out_valid), 784'(1));
        check_eq("chk_ok_addr",  784'(kernel_out_addr), 784'(11'd5));
        check_eq("chk_ok_bits",  784'(kernel_out_bits), 784'(25'h06A2C48));
        check_eq("chk_img_hold", image_out, exp_img);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
